// File: rtl/garbage_collector.sv
// Wear-leveling garbage-collection responder: accepts an erase command, runs the
// flash erase req/ack handshake with timeout, then flags the block in the BET.
module garbage_collector #(
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              garbage_en,
  input  logic [ADDR_W-1:0] garbage_addr,
  output logic              garbage_state,
  output logic              flash_erase_req,
  output logic [ADDR_W-1:0] flash_erase_addr,
  input  logic              flash_erase_ack,
  input  logic              flash_erase_fail,
  output logic [ADDR_W-1:0] bet_addr,
  output logic              bet_w,
  output logic              bet_w_en,
  output logic [CNT_W-1:0]  e_cnt,
  output logic              erase_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, BET_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              bwe_q, bwe_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      IDLE: begin
        if (garbage_en) begin
          addr_d  = garbage_addr;
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // ack is checked first so an ack on the final timeout cycle still wins
        if (flash_erase_ack) begin
          if (flash_erase_fail) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = BET_WR;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      BET_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they are derived from the state being entered.
    busy_d = (state_d != IDLE);
    req_d  = (state_d == WAIT_ACK);
    bwe_d  = (state_d == BET_WR);
    if (bwe_d && !(&ecnt_q)) begin
      ecnt_d = ecnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      bwe_q   <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      bwe_q   <= bwe_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign garbage_state    = busy_q;
  assign flash_erase_req  = req_q;
  assign flash_erase_addr = addr_q;
  assign bet_addr         = addr_q;
  assign bet_w            = bwe_q;
  assign bet_w_en         = bwe_q;
  assign e_cnt            = ecnt_q;
  assign erase_err        = err_q;

endmodule

// File: tb/tb_garbage_collector.sv
// Bench for garbage_collector: directed vector table, reset and saturation
// sequences, and randomized commands checked against a transaction-level model.
module tb_garbage_collector;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 4;
  localparam int TMO    = 16;
  localparam int WIN    = 40;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk_50 = 1'b0;
  logic              rst;
  logic              garbage_en;
  logic [ADDR_W-1:0] garbage_addr;
  logic              garbage_state;
  logic              flash_erase_req;
  logic [ADDR_W-1:0] flash_erase_addr;
  logic              flash_erase_ack;
  logic              flash_erase_fail;
  logic [ADDR_W-1:0] bet_addr;
  logic              bet_w;
  logic              bet_w_en;
  logic [CNT_W-1:0]  e_cnt;
  logic              erase_err;

  int checks = 0;
  int errors = 0;
  int ecnt_m = 0;

  garbage_collector #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk_50(clk_50), .rst(rst), .garbage_en(garbage_en), .garbage_addr(garbage_addr),
    .garbage_state(garbage_state), .flash_erase_req(flash_erase_req),
    .flash_erase_addr(flash_erase_addr), .flash_erase_ack(flash_erase_ack),
    .flash_erase_fail(flash_erase_fail), .bet_addr(bet_addr), .bet_w(bet_w),
    .bet_w_en(bet_w_en), .e_cnt(e_cnt), .erase_err(erase_err)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int lat;
    bit fl;
    bit noisy;
    int busy;
    int req;
    int bet;
    int err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Expected outcome of one command whose ack arrives lat cycles after req rises.
  function automatic void model(input int lat, input bit fl,
                                output int busy, output int req, output int bet, output int err);
    bit acked = (lat <= TMO - 1);
    bit ok    = acked && !fl;
    req  = acked ? lat + 1 : TMO;
    busy = ok ? lat + 3 : req;
    bet  = ok ? 1 : 0;
    err  = ok ? 0 : 1;
  endfunction

  task automatic run_txn(input logic [ADDR_W-1:0] a, input int lat, input bit fl,
                         input bit noisy, input int busy_exp,
                         output int busy, output int req, output int bet, output int bet_k,
                         output int err, output int err_k, output int viol);
    busy = 0; req = 0; bet = 0; bet_k = -1; err = 0; err_k = -1; viol = 0;
    garbage_en = 1'b1; garbage_addr = a;
    flash_erase_ack = 1'b0; flash_erase_fail = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk_50); #1;
      if (garbage_state === 1'b1) busy++;
      if (flash_erase_req === 1'b1) begin
        req++;
        if (flash_erase_addr !== a) viol++;
      end
      if (bet_w_en === 1'b1) begin
        bet++; bet_k = k;
        if (bet_addr !== a || bet_w !== 1'b1) viol++;
      end else if (bet_w !== 1'b0) viol++;
      if (erase_err === 1'b1) begin
        err++; err_k = k;
      end
      garbage_en   = noisy && (k < busy_exp) && ((k == 1) || ($urandom_range(1, 0) == 1));
      garbage_addr = (noisy && (k % 2 == 1)) ? 12'h7FF : ADDR_W'($urandom);
      flash_erase_ack  = (k == lat) || (noisy && k >= busy_exp && $urandom_range(3, 0) == 0);
      flash_erase_fail = (k == lat) ? fl : (noisy && $urandom_range(1, 0) == 1);
    end
    garbage_en = 1'b0; flash_erase_ack = 1'b0; flash_erase_fail = 1'b0;
  endtask

  task automatic do_txn(input string nm, input logic [ADDR_W-1:0] a, input int lat,
                        input bit fl, input bit noisy,
                        input int xbusy, input int xreq, input int xbet, input int xerr);
    int busy, req, bet, bet_k, err, err_k, viol;
    run_txn(a, lat, fl, noisy, xbusy, busy, req, bet, bet_k, err, err_k, viol);
    chk({nm, ".busy"}, busy, xbusy);
    chk({nm, ".req"}, req, xreq);
    chk({nm, ".bet"}, bet, xbet);
    chk({nm, ".err"}, err, xerr);
    chk({nm, ".viol"}, viol, 0);
    if (xbet != 0) chk({nm, ".bet_k"}, bet_k, lat + 1);
    if (xerr != 0) chk({nm, ".err_k"}, err_k, xreq);
    if (xbet != 0 && ecnt_m != CMAX) ecnt_m++;
    chk({nm, ".e_cnt"}, e_cnt, ecnt_m);
  endtask

  initial begin
    tbl[0] = '{12'h0A5,  5, 1'b0, 1'b0,  8,  6, 1, 0};
    tbl[1] = '{12'h123,  3, 1'b1, 1'b0,  4,  4, 0, 1};
    tbl[2] = '{12'h3C3, 30, 1'b0, 1'b0, 16, 16, 0, 1};
    tbl[3] = '{12'h100,  4, 1'b0, 1'b1,  7,  5, 1, 0};
    tbl[4] = '{12'h0FF, 15, 1'b0, 1'b0, 18, 16, 1, 0};
    tbl[5] = '{12'h001,  0, 1'b0, 1'b0,  3,  1, 1, 0};
    tbl[6] = '{12'h555, 16, 1'b1, 1'b0, 16, 16, 0, 1};
    tbl[7] = '{12'hFFF,  0, 1'b1, 1'b0,  1,  1, 0, 1};

    rst = 1'b0; garbage_en = 1'b0; garbage_addr = '0;
    flash_erase_ack = 1'b0; flash_erase_fail = 1'b0;
    #1;
    chk("rst.state", garbage_state, 0);
    chk("rst.req", flash_erase_req, 0);
    chk("rst.bwe", bet_w_en, 0);
    chk("rst.ecnt", e_cnt, 0);
    chk("rst.err", erase_err, 0);
    repeat (2) @(posedge clk_50);
    #2 rst = 1'b1;
    @(posedge clk_50); #1;

    foreach (tbl[i])
      do_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].lat, tbl[i].fl, tbl[i].noisy,
             tbl[i].busy, tbl[i].req, tbl[i].bet, tbl[i].err);

    // Asynchronous reset in the middle of WAIT_ACK.
    garbage_en = 1'b1; garbage_addr = 12'h0F0;
    @(posedge clk_50); #1;
    garbage_en = 1'b0;
    chk("mid.req_before", flash_erase_req, 1);
    repeat (2) @(posedge clk_50);
    #3 rst = 1'b0;
    #1;
    chk("mid.req", flash_erase_req, 0);
    chk("mid.state", garbage_state, 0);
    chk("mid.bwe", bet_w_en, 0);
    chk("mid.ecnt", e_cnt, 0);
    ecnt_m = 0;
    repeat (2) @(posedge clk_50);
    #2 rst = 1'b1;
    @(posedge clk_50); #1;
    flash_erase_ack = 1'b1;
    @(posedge clk_50); #1;
    flash_erase_ack = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    chk("mid.state_after", garbage_state, 0);
    chk("mid.bwe_after", bet_w_en, 0);
    chk("mid.ecnt_after", e_cnt, 0);

    for (int n = 0; n < 40; n++) begin
      int lat, xb, xr, xbt, xe;
      bit fl;
      lat = $urandom_range(24, 0);
      fl  = ($urandom_range(3, 0) == 0);
      model(lat, fl, xb, xr, xbt, xe);
      do_txn($sformatf("rnd%0d", n), ADDR_W'($urandom), lat, fl, ($urandom_range(1, 0) == 1),
             xb, xr, xbt, xe);
    end

    // Drive the counter into saturation; BET writes must continue after it.
    for (int n = 0; n < CMAX + 2 && ecnt_m < CMAX; n++)
      do_txn($sformatf("fill%0d", n), ADDR_W'($urandom), 2, 1'b0, 1'b0, 5, 3, 1, 0);
    do_txn("sat0", 12'hABC, 1, 1'b0, 1'b0, 4, 2, 1, 0);
    do_txn("sat1", 12'h00F, 7, 1'b0, 1'b1, 10, 8, 1, 0);
    chk("sat.value", e_cnt, CMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
